// File: rtl/csoc_scan_ctrl.sv
// csoc_scan_ctrl
//   Byte-command engine sitting between uart_rx/uart_tx and the CSoC test pins.
//   Drives CHAINS parallel scan chains, a divided CSoC clock, counted SHIFT and
//   RUN bursts, a CSoC reset sequence and a status readback.
//
//   Optional feature macro: CSOC_SCAN_ECHO_EN
//     defined   - every accepted byte is echoed through RESP before it is used
//     undefined - only SHIFT scan-out bytes and STATUS are transmitted
//
// Parameters
//   CHAINS   number of parallel scan chains (1..8)
//   CLK_DIV  clk cycles per csoc_clk half-period (1..255)
//
// Ports
//   clk, rstn                  system clock, async active-low reset
//   rx_data, rx_valid          received byte and its one-cycle strobe
//   tx_data, tx_start          byte to transmit and its one-cycle strobe
//   tx_ready                   transmitter idle
//   csoc_clk, csoc_rstn        generated CSoC clock and reset
//   csoc_test_se, csoc_test_tm scan enable, test mode
//   scan_in, scan_out          per-chain scan data to / from the CSoC
//   busy                       FSM not in IDLE
//   err                        sticky error (bad opcode or RX overrun)
module csoc_scan_ctrl #(
  parameter int unsigned CHAINS  = 1,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_ready,
  output logic              csoc_clk,
  output logic              csoc_rstn,
  output logic              csoc_test_se,
  output logic              csoc_test_tm,
  output logic [CHAINS-1:0] scan_in,
  input  logic [CHAINS-1:0] scan_out,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, ARG, DATA, PULSE_LO, PULSE_HI, RESP, RSTSEQ
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t            state;
  state_t            resp_ret;     // where RESP goes once its byte is sent
  logic              hold_valid;
  logic [7:0]        hold_data;
  logic [8:0]        cnt;          // burst / half-period counter, 256 fits
  logic [7:0]        div;
  logic              is_shift;
  logic [CHAINS-1:0] samp;
  logic              boot;         // first cycle after reset release

  logic              rx_state;
  logic              byte_go;      // a byte is ready to be acted upon
  logic              take_hold;    // holding register is emptied this cycle
  logic [7:0]        byte_in;

`ifdef CSOC_SCAN_ECHO_EN
  logic              replay;       // echoed byte waiting to be processed
  logic [7:0]        ebyte;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    rx_state  = (state == IDLE) || (state == ARG) || (state == DATA);
`ifdef CSOC_SCAN_ECHO_EN
    // A byte is first moved out of the holding register and echoed; it is
    // processed from ebyte when RESP returns to the capturing state.
    byte_go   = rx_state && replay;
    byte_in   = ebyte;
    take_hold = rx_state && !replay && hold_valid;
`else
    byte_go   = rx_state && hold_valid;
    byte_in   = hold_data;
    take_hold = byte_go;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      resp_ret     <= IDLE;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      cnt          <= '0;
      div          <= '0;
      is_shift     <= 1'b0;
      samp         <= '0;
      boot         <= 1'b0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      csoc_clk     <= 1'b0;
      csoc_rstn    <= 1'b0;
      csoc_test_se <= 1'b0;
      csoc_test_tm <= 1'b0;
      scan_in      <= '0;
      err          <= 1'b0;
`ifdef CSOC_SCAN_ECHO_EN
      replay       <= 1'b0;
      ebyte        <= '0;
`endif
    end else begin
      if (!boot) begin
        boot      <= 1'b1;
        csoc_rstn <= 1'b1;
      end

      case (state)
        IDLE, ARG, DATA: begin
`ifdef CSOC_SCAN_ECHO_EN
          if (take_hold) begin
            ebyte    <= hold_data;
            replay   <= 1'b1;
            tx_data  <= hold_data;
            resp_ret <= state;
            state    <= RESP;
          end
          if (byte_go) replay <= 1'b0;
`endif
          if (byte_go) begin
            case (state)
              IDLE: begin
                case (byte_in)
                  8'h00: begin end
                  8'h01: begin
                    csoc_rstn <= 1'b0;
                    csoc_clk  <= 1'b0;
                    div       <= '0;
                    cnt       <= 9'd4;   // four half-periods = two clocks
                    state     <= RSTSEQ;
                  end
                  8'h02: csoc_test_tm <= 1'b1;
                  8'h03: csoc_test_tm <= 1'b0;
                  8'h10: begin
                    is_shift <= 1'b1;
                    state    <= ARG;
                  end
                  8'h11: begin
                    is_shift     <= 1'b0;
                    cnt          <= 9'd1;
                    csoc_test_se <= 1'b0;
                    div          <= '0;
                    state        <= PULSE_LO;
                  end
                  8'h12: begin
                    is_shift <= 1'b0;
                    state    <= ARG;
                  end
                  8'h7F: begin
                    tx_data  <= {err, csoc_test_tm, csoc_rstn, 5'b0};
                    err      <= 1'b0;
                    resp_ret <= IDLE;
                    state    <= RESP;
                  end
                  default: err <= 1'b1;
                endcase
              end
              ARG: begin
                cnt <= (byte_in == 8'd0) ? 9'd256 : {1'b0, byte_in};
                div <= '0;
                if (is_shift) begin
                  state <= DATA;
                end else begin
                  csoc_test_se <= 1'b0;
                  state        <= PULSE_LO;
                end
              end
              default: begin
                scan_in      <= byte_in[CHAINS-1:0];
                csoc_test_se <= 1'b1;
                div          <= '0;
                state        <= PULSE_LO;
              end
            endcase
          end
        end

        PULSE_LO: begin
          if (div == DIV_LAST) begin
            samp     <= scan_out;
            csoc_clk <= 1'b1;
            div      <= '0;
            state    <= PULSE_HI;
          end else begin
            div <= div + 8'd1;
          end
        end

        PULSE_HI: begin
          if (div == DIV_LAST) begin
            csoc_clk <= 1'b0;
            div      <= '0;
            cnt      <= cnt - 9'd1;
            if (is_shift) begin
              tx_data  <= 8'(samp);
              resp_ret <= (cnt == 9'd1) ? IDLE : DATA;
              if (cnt == 9'd1) csoc_test_se <= 1'b0;
              state    <= RESP;
            end else if (cnt == 9'd1) begin
              state <= IDLE;
            end else begin
              state <= PULSE_LO;
            end
          end else begin
            div <= div + 8'd1;
          end
        end

        RESP: begin
          if (tx_start) begin
            tx_start <= 1'b0;
            state    <= resp_ret;
          end else if (tx_ready) begin
            tx_start <= 1'b1;
          end
        end

        RSTSEQ: begin
          if (div == DIV_LAST) begin
            div      <= '0;
            csoc_clk <= ~csoc_clk;
            cnt      <= cnt - 9'd1;
            if (cnt == 9'd1) begin
              csoc_rstn <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            div <= div + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase

      // Placed after the FSM so an overrun in the same cycle as a STATUS
      // clear leaves err set.
      if (rx_valid) begin
        if (hold_valid && !take_hold) begin
          err <= 1'b1;
        end else begin
          hold_valid <= 1'b1;
          hold_data  <= rx_data;
        end
      end else if (take_hold) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csoc_scan_ctrl.sv
module tb_csoc_scan_ctrl;
  localparam int unsigned CH = 4;
  localparam int unsigned CD = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_ready;
  logic          csoc_clk;
  logic          csoc_rstn;
  logic          csoc_test_se;
  logic          csoc_test_tm;
  logic [CH-1:0] scan_in;
  logic [CH-1:0] scan_out;
  logic          busy;
  logic          err;

  csoc_scan_ctrl #(.CHAINS(CH), .CLK_DIV(CD)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn), .csoc_test_se(csoc_test_se),
    .csoc_test_tm(csoc_test_tm), .scan_in(scan_in), .scan_out(scan_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Passive observers: transmitted bytes, CSoC rising edges with the scan
  // pins seen at that edge, and cycle stamps of those edges.
  logic [7:0] tx_q[$];
  logic [4:0] rise_q[$];
  int         rise_cyc[$];
  int         cyc = 0;
  logic       prev_cclk = 1'b0;
  logic       prev_txs = 1'b0;
  int         double_tx = 0;

  always @(negedge clk) begin
    cyc++;
    if (tx_start) tx_q.push_back(tx_data);
    if (tx_start && prev_txs) double_tx++;
    if (csoc_clk && !prev_cclk) begin
      rise_q.push_back({csoc_test_se, scan_in});
      rise_cyc.push_back(cyc);
    end
    prev_cclk = csoc_clk;
    prev_txs  = tx_start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int lim);
    int k = 0;
    repeat (3) @(negedge clk);
    while (busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'b0, busy}, 32'd0);
  endtask

  task automatic expect_tx(input string name, input logic [7:0] exp);
    int k = 0;
    while (tx_q.size() == 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, "_avail"}, tx_q.size() != 0, 32'd1);
    if (tx_q.size() != 0) check(name, tx_q.pop_front(), {24'b0, exp});
  endtask

  function automatic logic [7:0] status_byte(input logic e, input logic tm, input logic rs);
    return {e, tm, rs, 5'b0};
  endfunction

  // Model: each data byte yields one rising edge with se=1 and scan_in equal
  // to the byte's low CH bits, and one tx byte equal to the scan_out value.
  task automatic shift_burst(input int n, input logic [7:0] d[$], input logic [CH-1:0] so);
    logic [4:0] r;
    rise_q.delete(); rise_cyc.delete(); tx_q.delete();
    scan_out = so;
    send(8'h10); wait_cyc(3);
    send(8'(n)); wait_cyc(3);
    for (int i = 0; i < n; i++) begin
      send(d[i]);
      wait_cyc(12);
    end
    wait_idle("shift_idle", 100);
    check("shift_rises", rise_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (rise_q.size() > 0) begin
        r = rise_q.pop_front();
        check("shift_se", {31'b0, r[4]}, 32'd1);
        check("shift_scan_in", {28'b0, r[3:0]}, {28'b0, d[i][3:0]});
      end
    end
    check("shift_ntx", tx_q.size(), n);
    for (int i = 0; i < n; i++)
      if (tx_q.size() > 0) check("shift_tx", tx_q.pop_front(), {28'b0, so});
    check("shift_se_after", {31'b0, csoc_test_se}, 32'd0);
  endtask

  task automatic run_burst(input int k, input int lim);
    int bad_se = 0;
    int bad_per = 0;
    rise_q.delete(); rise_cyc.delete(); tx_q.delete();
    send(8'h12); wait_cyc(3);
    send(8'(k));
    wait_idle("run_idle", lim);
    check("run_rises", rise_q.size(), k);
    foreach (rise_q[i]) if (rise_q[i][4]) bad_se++;
    for (int i = 1; i < rise_cyc.size(); i++)
      if (rise_cyc[i] - rise_cyc[i-1] != 2 * CD) bad_per++;
    check("run_se", bad_se, 0);
    check("run_period", bad_per, 0);
    check("run_no_tx", tx_q.size(), 0);
  endtask

  typedef struct {
    logic [7:0] op;
    logic       exp_tm;
    logic [7:0] exp_status;
  } vec_t;

  vec_t vt[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [7:0] d[$];
    logic [CH-1:0] so;

    // Each op is followed by STATUS; status = {err, tm, csoc_rstn, 5'b0}.
    vt[0] = '{8'h02, 1'b1, 8'h60};  // TM_ON
    vt[1] = '{8'h55, 1'b1, 8'hE0};  // illegal: err
    vt[2] = '{8'h00, 1'b1, 8'h60};  // err cleared by previous STATUS
    vt[3] = '{8'h03, 1'b0, 8'h20};  // TM_OFF
    vt[4] = '{8'hFF, 1'b0, 8'hA0};  // illegal with tm=0
    vt[5] = '{8'h01, 1'b0, 8'h20};  // RST sequence completes, rstn=1
    vt[6] = '{8'h02, 1'b1, 8'h60};

    rstn = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1; scan_out = '0;
    repeat (3) @(negedge clk);
    check("rst_csoc_clk", {31'b0, csoc_clk}, 32'd0);
    check("rst_csoc_rstn", {31'b0, csoc_rstn}, 32'd0);
    check("rst_se_tm", {30'b0, csoc_test_se, csoc_test_tm}, 32'd0);
    check("rst_scan_in", {28'b0, scan_in}, 32'd0);
    check("rst_tx", {23'b0, tx_start, tx_data}, 32'd0);
    check("rst_busy_err", {30'b0, busy, err}, 32'd0);
    rstn = 1'b1;
    #1 check("rstn_before_edge", {31'b0, csoc_rstn}, 32'd0);
    @(posedge clk); #1;
    check("rstn_first_edge", {31'b0, csoc_rstn}, 32'd1);
    wait_cyc(2);

    // Table-driven opcode / status vectors
    tx_q.delete();
    for (int i = 0; i < 7; i++) begin
      send(vt[i].op);
      wait_cyc(20);
      check("tm_level", {31'b0, csoc_test_tm}, {31'b0, vt[i].exp_tm});
      send(8'h7F);
      expect_tx("status", vt[i].exp_status);
    end
    send(8'h03); wait_cyc(5);  // tm back to 0

    // SHIFT 2 with latency measurement on the first data byte
    rise_q.delete(); rise_cyc.delete(); tx_q.delete();
    scan_out = 4'b1001;
    send(8'h10); wait_cyc(3);
    send(8'h02); wait_cyc(3);
    @(negedge clk);
    rx_data = 8'h05; rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!csoc_clk && lat < 50);
    check("strobe_to_rise", lat, CD + 1);
    lat = 0;
    while (csoc_clk && lat < 50) begin @(posedge clk); #1; lat++; end
    lat = 0;
    while (!tx_start && lat < 50) begin @(posedge clk); #1; lat++; end
    check("fall_to_tx", lat, 1);
    wait_cyc(8);
    send(8'h0A); wait_cyc(12);
    wait_idle("shift2_idle", 50);
    check("shift2_rises", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      check("shift2_r0", {27'b0, rise_q[0]}, {27'b0, 5'b1_0101});
      check("shift2_r1", {27'b0, rise_q[1]}, {27'b0, 5'b1_1010});
    end
    check("shift2_ntx", tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      check("shift2_tx0", tx_q[0], 32'h09);
      check("shift2_tx1", tx_q[1], 32'h09);
    end
    check("shift2_se_off", {31'b0, csoc_test_se}, 32'd0);

    // RUN 0 -> 256 pulses
    run_burst(256, 3000);

    // Byte accepted in the same cycle the holding register empties
    tx_q.delete();
    @(negedge clk); rx_data = 8'h00; rx_valid = 1'b1;
    @(negedge clk); rx_data = 8'h00;
    @(negedge clk); rx_valid = 1'b0;
    wait_cyc(5);
    check("simul_no_err", {31'b0, err}, 32'd0);

    // tx_ready held low: RESP stalls, one extra byte held, the next dropped
    tx_q.delete(); rise_q.delete(); rise_cyc.delete();
    scan_out = 4'b1001; tx_ready = 1'b0;
    send(8'h10); wait_cyc(3);
    send(8'h01); wait_cyc(3);
    send(8'h03); wait_cyc(12);
    send(8'h00); wait_cyc(3);
    send(8'h00); wait_cyc(3);
    check("stall_no_tx", tx_q.size(), 0);
    check("stall_busy", {31'b0, busy}, 32'd1);
    check("overrun_err", {31'b0, err}, 32'd1);
    tx_ready = 1'b1;
    expect_tx("stall_resp", 8'h09);
    wait_idle("stall_idle", 50);
    wait_cyc(5);
    send(8'h7F);
    expect_tx("status_err", status_byte(1'b1, 1'b0, 1'b1));
    send(8'h7F);
    expect_tx("status_clr", status_byte(1'b0, 1'b0, 1'b1));

    // Randomised SHIFT and RUN bursts against the model
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 5);
      d.delete();
      for (int j = 0; j < n; j++) d.push_back(8'($urandom));
      so = CH'($urandom);
      shift_burst(n, d, so);
      run_burst($urandom_range(1, 12), 200);
    end

    // Reset asserted in the middle of a RUN burst
    send(8'h02); wait_cyc(3);
    send(8'h12); wait_cyc(3);
    send(8'h00); wait_cyc(30);
    @(negedge clk); rstn = 1'b0;
    #1;
    check("mid_rst_clk", {31'b0, csoc_clk}, 32'd0);
    check("mid_rst_csoc_rstn", {31'b0, csoc_rstn}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_se_tm", {30'b0, csoc_test_se, csoc_test_tm}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    #1 check("mid_rel_rstn_low", {31'b0, csoc_rstn}, 32'd0);
    @(posedge clk); #1;
    check("mid_rel_rstn_high", {31'b0, csoc_rstn}, 32'd1);
    wait_cyc(3);
    check("mid_rel_idle", {31'b0, busy}, 32'd0);
    tx_q.delete();
    send(8'h7F);
    expect_tx("status_after_rst", status_byte(1'b0, 1'b0, 1'b1));

    check("tx_start_single", double_tx, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
